// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the M stage.
// Turns one load/store from the pipeline into a single DMEM request/response
// transaction, formats store lanes, flags misaligned accesses and hands the
// raw load word plus its size/offset to the downstream load extender.
module dmem_access_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_fnc,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        misaligned,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic        mem_req_we,
   output logic [3:0]  mem_req_wmask,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic [31:0] ld_data,
   output logic [2:0]  ld_sel,
   output logic [1:0]  ld_off,
   output logic        ld_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  fnc_q, fnc_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic        mis;

   // Halfwords need an even address, words a multiple of four; bytes never fault.
   function automatic logic is_mis(input logic [2:0] fnc, input logic [1:0] off);
      logic m;
      m = 1'b0;
      case (fnc)
         3'b001, 3'b101: m = off[0];
         3'b010:         m = (off != 2'b00);
         default:        m = 1'b0;
      endcase
      return m;
   endfunction

   // Byte-lane enables for a store; loads never write any lane.
   function automatic logic [3:0] fmt_wmask(input logic we, input logic [1:0] size,
                                            input logic [1:0] off);
      logic [3:0] m;
      m = 4'b0000;
      if (we) begin
         case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
         endcase
      end
      return m;
   endfunction

   // Replicate the store source across the lanes so the mask alone selects bytes.
   function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] rs2);
      logic [31:0] d;
      case (size)
         2'b00:   d = {4{rs2[7:0]}};
         2'b01:   d = {2{rs2[15:0]}};
         default: d = rs2;
      endcase
      return d;
   endfunction

   // State register and captured transaction fields; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         fnc_q     <= 3'b000;
         off_q     <= 2'b00;
         addr_q    <= 32'h0;
         wmask_q   <= 4'h0;
         wdata_q   <= 32'h0;
         ld_data_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         fnc_q     <= fnc_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         wmask_q   <= wmask_d;
         wdata_q   <= wdata_d;
         ld_data_q <= ld_data_d;
      end
   end

   // Next state, field capture on acceptance, and the per-state control outputs.
   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      fnc_d         = fnc_q;
      off_d         = off_q;
      addr_d        = addr_q;
      wmask_d       = wmask_q;
      wdata_d       = wdata_q;
      ld_data_d     = ld_data_q;
      stall         = 1'b0;
      misaligned    = 1'b0;
      mem_req_valid = 1'b0;
      ld_valid      = 1'b0;
      mis           = is_mis(req_fnc, req_addr[1:0]);
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (mis) begin
                  misaligned = 1'b1;
               end else begin
                  stall   = 1'b1;
                  state_d = ISSUE;
                  we_d    = req_we;
                  fnc_d   = req_fnc;
                  off_d   = req_addr[1:0];
                  addr_d  = {req_addr[31:2], 2'b00};
                  wmask_d = fmt_wmask(req_we, req_fnc[1:0], req_addr[1:0]);
                  wdata_d = fmt_wdata(req_fnc[1:0], req_wdata);
               end
            end
         end
         ISSUE: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (mem_resp_valid) begin
               state_d = DONE;
               if (!we_q) ld_data_d = mem_resp_data;
            end
         end
         DONE: begin
            ld_valid = ~we_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_req_addr  = addr_q;
   assign mem_req_we    = we_q;
   assign mem_req_wmask = wmask_q;
   assign mem_req_wdata = wdata_q;
   assign ld_data       = ld_data_q;
   assign ld_sel        = fnc_q;
   assign ld_off        = off_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [2:0]  req_fnc;
   logic [31:0] req_addr, req_wdata;
   logic        stall, misaligned, mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_we;
   logic [3:0]  mem_req_wmask;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic [31:0] ld_data;
   logic [2:0]  ld_sel;
   logic [1:0]  ld_off;
   logic        ld_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_access_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_fnc(req_fnc),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .misaligned(misaligned),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .ld_data(ld_data), .ld_sel(ld_sel), .ld_off(ld_off), .ld_valid(ld_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   function automatic bit bad_align(input logic [2:0] fnc, input logic [31:0] addr);
      if (fnc == 3'b001 || fnc == 3'b101) return (addr % 32'd2) != 0;
      if (fnc == 3'b010) return (addr % 32'd4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] exp_mask(input logic we, input logic [2:0] fnc,
                                           input logic [31:0] addr);
      if (!we) return 4'd0;
      if (fnc[1:0] == 2'd0) return 4'(1 << (addr % 4));
      if (fnc[1:0] == 2'd1) return 4'(3 << (((addr % 4) / 2) * 2));
      return 4'd15;
   endfunction

   function automatic logic [31:0] exp_data(input logic [2:0] fnc, input logic [31:0] rs2);
      if (fnc[1:0] == 2'd0) return (rs2 % 32'd256) * 32'h01010101;
      if (fnc[1:0] == 2'd1) return (rs2 % 32'd65536) * 32'h00010001;
      return rs2;
   endfunction

   bit          m_ok = 1'b0;
   bit          m_busy, m_acc, m_resp;
   logic        m_we;
   logic [2:0]  m_fnc;
   logic [1:0]  m_off;
   logic [31:0] m_addr, m_wdata, m_ld;
   logic [3:0]  m_wmask;
   bit          cmp_go;

   always @(posedge clk) begin
      if (rst) begin
         m_ok = 1'b1; m_busy = 1'b0; m_acc = 1'b0; m_resp = 1'b0;
         m_we = 1'b0; m_fnc = 3'd0; m_off = 2'd0; m_addr = 32'd0;
         m_wdata = 32'd0; m_ld = 32'd0; m_wmask = 4'd0;
      end else if (!m_busy) begin
         if (req_valid && !bad_align(req_fnc, req_addr)) begin
            m_busy  = 1'b1;
            m_we    = req_we;
            m_fnc   = req_fnc;
            m_off   = 2'(req_addr % 4);
            m_addr  = req_addr - (req_addr % 4);
            m_wmask = exp_mask(req_we, req_fnc, req_addr);
            m_wdata = exp_data(req_fnc, req_wdata);
         end
      end else if (m_resp) begin
         m_busy = 1'b0; m_acc = 1'b0; m_resp = 1'b0;
      end else if (!m_acc) begin
         if (mem_req_ready) m_acc = 1'b1;
      end else if (mem_resp_valid) begin
         m_resp = 1'b1;
         if (!m_we) m_ld = mem_resp_data;
      end
   end

   // Compare every output against the model each cycle
   always @(negedge clk) begin
      if (m_ok) begin
         cmp_go = !m_busy && req_valid && !bad_align(req_fnc, req_addr);
         chk("stall", 32'(stall), 32'(cmp_go || (m_busy && !m_resp)));
         chk("misaligned", 32'(misaligned),
             32'(!m_busy && req_valid && bad_align(req_fnc, req_addr)));
         chk("mem_req_valid", 32'(mem_req_valid), 32'(m_busy && !m_acc));
         chk("mem_req_addr", mem_req_addr, m_addr);
         chk("mem_req_we", 32'(mem_req_we), 32'(m_we));
         chk("mem_req_wmask", 32'(mem_req_wmask), 32'(m_wmask));
         chk("mem_req_wdata", mem_req_wdata, m_wdata);
         chk("ld_data", ld_data, m_ld);
         chk("ld_sel", 32'(ld_sel), 32'(m_fnc));
         chk("ld_off", 32'(ld_off), 32'(m_off));
         chk("ld_valid", 32'(ld_valid), 32'(m_resp && !m_we));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_we = 1'b0; req_fnc = 3'd0; req_addr = 32'd0;
      req_wdata = 32'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      mem_resp_data = 32'd0;
   endtask

   task automatic garbage_req();
      req_valid = 1'($urandom); req_we = 1'($urandom); req_fnc = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
   endtask

   task automatic count(inout int st, inout int lv);
      if (stall) st++;
      if (ld_valid) lv++;
   endtask

   task automatic do_txn(input logic we, input logic [2:0] fnc, input logic [31:0] addr,
                         input logic [31:0] rs2, input int rdly, input int sdly,
                         input logic [31:0] rdata, input bit inject,
                         output int st, output int lv, output int lv_done);
      logic [31:0] a0, d0;
      logic [3:0]  m0;
      logic        w0;
      st = 0; lv = 0; lv_done = 0;
      a0 = 32'd0; d0 = 32'd0; m0 = 4'd0; w0 = 1'b0;
      req_valid = 1'b1; req_we = we; req_fnc = fnc; req_addr = addr; req_wdata = rs2;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = $urandom;
      #2 count(st, lv);
      tick();
      for (int i = 0; i <= rdly; i++) begin
         garbage_req();
         mem_req_ready  = (i == rdly);
         mem_resp_valid = inject && (i == 0);
         mem_resp_data  = $urandom;
         #2 count(st, lv);
         if (i == 0) begin
            a0 = mem_req_addr; d0 = mem_req_wdata; m0 = mem_req_wmask; w0 = mem_req_we;
         end else begin
            chk("hold_addr", mem_req_addr, a0);
            chk("hold_wdata", mem_req_wdata, d0);
            chk("hold_wmask", 32'(mem_req_wmask), 32'(m0));
            chk("hold_we", 32'(mem_req_we), 32'(w0));
         end
         tick();
      end
      for (int j = 0; j <= sdly; j++) begin
         garbage_req();
         mem_req_ready  = 1'($urandom);
         mem_resp_valid = (j == sdly);
         mem_resp_data  = (j == sdly) ? rdata : $urandom;
         #2 count(st, lv);
         tick();
      end
      garbage_req();
      mem_req_ready  = 1'($urandom);
      mem_resp_valid = 1'($urandom);
      mem_resp_data  = $urandom;
      #2 count(st, lv);
      if (ld_valid) lv_done = 1;
      tick();
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      int st, lv, lvd;
      logic [2:0] ftab [5];
      ftab[0] = 3'b000; ftab[1] = 3'b001; ftab[2] = 3'b010;
      ftab[3] = 3'b100; ftab[4] = 3'b101;

      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_addr", mem_req_addr, 32'd0);
      chk("rst_wmask", 32'(mem_req_wmask), 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_ld_valid", 32'(ld_valid), 32'd0);
      tick();

      // LW at 0x100, immediate ready and response
      do_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, st, lv, lvd);
      chk("lw_stall_cycles", 32'(st), 32'd3);
      chk("lw_ldv_count", 32'(lv), 32'd1);
      chk("lw_ldv_cycle4", 32'(lvd), 32'd1);
      #2;
      chk("lw_ld_data", ld_data, 32'hDEADBEEF);
      chk("lw_ld_sel", 32'(ld_sel), 32'd2);
      chk("lw_ld_off", 32'(ld_off), 32'd0);
      tick();

      // SB at 0x203
      do_txn(1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0, 1'b0, st, lv, lvd);
      #2;
      chk("sb_addr", mem_req_addr, 32'h200);
      chk("sb_wmask", 32'(mem_req_wmask), 32'h8);
      chk("sb_wdata", mem_req_wdata, 32'hA5A5A5A5);
      chk("sb_we", 32'(mem_req_we), 32'd1);
      chk("sb_ldv_count", 32'(lv), 32'd0);
      chk("sb_ld_data_kept", ld_data, 32'hDEADBEEF);
      tick();

      // SH at 0x302
      do_txn(1'b1, 3'b001, 32'h302, 32'h1234BEEF, 1, 1, 32'h0, 1'b0, st, lv, lvd);
      #2;
      chk("sh_wmask", 32'(mem_req_wmask), 32'hC);
      chk("sh_wdata", mem_req_wdata, 32'hBEEFBEEF);
      chk("sh_addr", mem_req_addr, 32'h300);
      tick();

      // Misaligned LW at 0x101 then LH at 0x103
      req_valid = 1'b1; req_we = 1'b0; req_fnc = 3'b010; req_addr = 32'h101;
      #2;
      chk("mis_lw_flag", 32'(misaligned), 32'd1);
      chk("mis_lw_stall", 32'(stall), 32'd0);
      chk("mis_lw_memreq", 32'(mem_req_valid), 32'd0);
      tick();
      idle_inputs();
      #2 chk("mis_lw_pulse_end", 32'(misaligned), 32'd0);
      tick();
      req_valid = 1'b1; req_we = 1'b0; req_fnc = 3'b001; req_addr = 32'h103;
      #2;
      chk("mis_lh_flag", 32'(misaligned), 32'd1);
      chk("mis_lh_stall", 32'(stall), 32'd0);
      tick();
      idle_inputs();
      #2;
      chk("mis_lh_pulse_end", 32'(misaligned), 32'd0);
      chk("mis_lh_memreq", 32'(mem_req_valid), 32'd0);
      tick();

      // Backpressure: ready after 5 cycles, resp after 3, stray resp during ISSUE
      do_txn(1'b0, 3'b010, 32'h400, 32'h0, 5, 3, 32'hCAFEF00D, 1'b1, st, lv, lvd);
      chk("bp_stall_cycles", 32'(st), 32'd11);
      chk("bp_ldv_count", 32'(lv), 32'd1);
      #2 chk("bp_ld_data", ld_data, 32'hCAFEF00D);
      tick();

      // Reset during WAIT, then LBU at 0x001 right away
      req_valid = 1'b1; req_we = 1'b0; req_fnc = 3'b010; req_addr = 32'h500;
      tick();
      idle_inputs(); mem_req_ready = 1'b1;
      tick();
      idle_inputs(); rst = 1'b1;
      tick();
      rst = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_fnc = 3'b100; req_addr = 32'h001;
      #2;
      chk("rw_ld_valid", 32'(ld_valid), 32'd0);
      chk("rw_memreq", 32'(mem_req_valid), 32'd0);
      chk("rw_ld_data", ld_data, 32'd0);
      chk("rw_addr", mem_req_addr, 32'd0);
      chk("rw_ld_off", 32'(ld_off), 32'd0);
      chk("rw_new_stall", 32'(stall), 32'd1);
      tick();
      idle_inputs(); mem_req_ready = 1'b1;
      #2;
      chk("rw_lbu_issue", 32'(mem_req_valid), 32'd1);
      chk("rw_lbu_off", 32'(ld_off), 32'd1);
      chk("rw_lbu_sel", 32'(ld_sel), 32'd4);
      chk("rw_lbu_addr", mem_req_addr, 32'd0);
      tick();
      idle_inputs(); mem_resp_valid = 1'b1; mem_resp_data = 32'h11223344;
      tick();
      idle_inputs();
      #2;
      chk("rw_lbu_ldv", 32'(ld_valid), 32'd1);
      chk("rw_lbu_data", ld_data, 32'h11223344);
      tick();

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic [2:0]  f;
         logic [31:0] a;
         logic        w;
         int          rd, sd;
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1; tick(); rst = 1'b0;
         end
         if ($urandom_range(0, 4) == 0) tick();
         f  = ftab[$urandom_range(0, 4)];
         w  = (f[2] == 1'b0) ? 1'($urandom) : 1'b0;
         a  = $urandom;
         rd = $urandom_range(0, 4);
         sd = $urandom_range(0, 4);
         if (bad_align(f, a)) begin
            req_valid = 1'b1; req_we = w; req_fnc = f; req_addr = a; req_wdata = $urandom;
            tick();
            idle_inputs();
         end else begin
            do_txn(w, f, a, $urandom, rd, sd, $urandom, 1'($urandom), st, lv, lvd);
            chk("rnd_stall_cycles", 32'(st), 32'(3 + rd + sd));
            chk("rnd_ldv_count", 32'(lv), w ? 32'd0 : 32'd1);
         end
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
